// File: rtl/reindeer_trap_sequencer_pkg.sv
// rtl/reindeer_trap_sequencer_pkg.sv - shared widths, FSM states and cause codes for the trap sequencer
package reindeer_trap_sequencer_pkg;

   localparam int XLEN                = 32;
   localparam int PC_BITWIDTH         = 32;
   localparam int EXCEPTION_CODE_BITS = 4;

   localparam logic [EXCEPTION_CODE_BITS-1:0] INTERRUPT_MACHINE_TIMER    = 4'd7;
   localparam logic [EXCEPTION_CODE_BITS-1:0] INTERRUPT_MACHINE_EXTERNAL = 4'd11;

   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ENTER    = 2'd1,
      ST_MRET     = 2'd2,
      ST_REDIRECT = 2'd3
   } trap_state_t;

   typedef enum logic [2:0] {
      SEL_NONE = 3'd0,
      SEL_EXC  = 3'd1,
      SEL_MRET = 3'd2,
      SEL_EXT  = 3'd3,
      SEL_TMR  = 3'd4
   } req_sel_t;

endpackage

// File: rtl/reindeer_trap_priority.sv
// rtl/reindeer_trap_priority.sv - fixed-priority selection of the winning trap/mret request
module reindeer_trap_priority
   import reindeer_trap_sequencer_pkg::*;
(
   input  logic                           exc_req,
   input  logic [EXCEPTION_CODE_BITS-1:0] exc_code,
   input  logic [PC_BITWIDTH-1:0]         exe_PC,
   input  logic [XLEN-1:0]                exc_addr,
   input  logic                           mret_req,
   input  logic [PC_BITWIDTH-1:0]         next_PC,
   input  logic                           mem_busy,
   input  logic                           in_trap,
   input  logic                           mie,
   input  logic                           mtie,
   input  logic                           meie,
   input  logic                           mtip,
   input  logic                           meip,
   output req_sel_t                       sel,
   output logic [EXCEPTION_CODE_BITS-1:0] sel_code,
   output logic [PC_BITWIDTH-1:0]         sel_pc,
   output logic [XLEN-1:0]                sel_addr,
   output logic                           sel_is_int
);

   logic ext_ok;
   logic tmr_ok;

   // Interrupts are masked while a handler runs or a memory access is in flight
   assign ext_ok = mie & meie & meip & ~in_trap & ~mem_busy;
   assign tmr_ok = mie & mtie & mtip & ~in_trap & ~mem_busy;

   // Exception beats mret beats external beats timer
   always_comb begin
      sel        = SEL_NONE;
      sel_code   = '0;
      sel_pc     = '0;
      sel_addr   = '0;
      sel_is_int = 1'b0;
      if (exc_req) begin
         sel      = SEL_EXC;
         sel_code = exc_code;
         sel_pc   = exe_PC;
         sel_addr = exc_addr;
      end else if (mret_req) begin
         sel = SEL_MRET;
      end else if (ext_ok) begin
         sel        = SEL_EXT;
         sel_code   = INTERRUPT_MACHINE_EXTERNAL;
         sel_pc     = next_PC;
         sel_is_int = 1'b1;
      end else if (tmr_ok) begin
         sel        = SEL_TMR;
         sel_code   = INTERRUPT_MACHINE_TIMER;
         sel_pc     = next_PC;
         sel_is_int = 1'b1;
      end
   end

endmodule

// File: rtl/reindeer_trap_sequencer.sv
// rtl/reindeer_trap_sequencer.sv - trap entry / mret sequencer; TRAP_VECTORED_MODE_EN enables vectored interrupts
module reindeer_trap_sequencer
   import reindeer_trap_sequencer_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           sync_reset,
   input  logic [PC_BITWIDTH-1:0]         exe_PC,
   input  logic [PC_BITWIDTH-1:0]         next_PC,
   input  logic                           exc_req,
   input  logic [EXCEPTION_CODE_BITS-1:0] exc_code,
   input  logic [XLEN-1:0]                exc_addr,
   input  logic                           mret_req,
   input  logic                           mem_busy,
   input  logic                           mie,
   input  logic                           mtie,
   input  logic                           meie,
   input  logic                           mtip,
   input  logic                           meip,
   input  logic [XLEN-1:0]                mtvec,
   input  logic [XLEN-1:0]                mepc,
   output logic                           activate_exception,
   output logic                           is_interrupt,
   output logic [EXCEPTION_CODE_BITS-1:0] exception_code,
   output logic [PC_BITWIDTH-1:0]         exception_PC,
   output logic [XLEN-1:0]                exception_addr,
   output logic                           csr_mret_active,
   output logic                           pc_redirect,
   output logic [PC_BITWIDTH-1:0]         redirect_PC,
   output logic                           pipeline_stall,
   output logic                           in_trap
);

   trap_state_t                    state_q;
   trap_state_t                    state_d;
   req_sel_t                       sel;
   logic [EXCEPTION_CODE_BITS-1:0] sel_code;
   logic [PC_BITWIDTH-1:0]         sel_pc;
   logic [XLEN-1:0]                sel_addr;
   logic                           sel_is_int;
   logic [PC_BITWIDTH-1:0]         vec_base;
   logic [PC_BITWIDTH-1:0]         target;

   reindeer_trap_priority u_priority (
      .exc_req    (exc_req),
      .exc_code   (exc_code),
      .exe_PC     (exe_PC),
      .exc_addr   (exc_addr),
      .mret_req   (mret_req),
      .next_PC    (next_PC),
      .mem_busy   (mem_busy),
      .in_trap    (in_trap),
      .mie        (mie),
      .mtie       (mtie),
      .meie       (meie),
      .mtip       (mtip),
      .meip       (meip),
      .sel        (sel),
      .sel_code   (sel_code),
      .sel_pc     (sel_pc),
      .sel_addr   (sel_addr),
      .sel_is_int (sel_is_int)
   );

   assign vec_base = {mtvec[XLEN-1:2], 2'b00};

   // Redirect target, evaluated in ENTER/MRET and registered into REDIRECT
`ifdef TRAP_VECTORED_MODE_EN
   always_comb begin
      target = vec_base;
      if (state_q == ST_MRET) begin
         target = mepc;
      end else if (is_interrupt && (mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
         target = vec_base + {26'd0, exception_code, 2'b00};
      end
   end
`else
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^mtvec[1:0];

   always_comb begin
      target = vec_base;
      if (state_q == ST_MRET) begin
         target = mepc;
      end
   end
`endif

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else if (sync_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: requests only considered in IDLE, every sequence ends in one redirect
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            case (sel)
               SEL_EXC, SEL_EXT, SEL_TMR: state_d = ST_ENTER;
               SEL_MRET:                  state_d = ST_MRET;
               default:                   state_d = ST_IDLE;
            endcase
         end
         ST_ENTER:    state_d = ST_REDIRECT;
         ST_MRET:     state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Registered strobes, latched cause data, redirect target and handler flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         activate_exception <= 1'b0;
         is_interrupt       <= 1'b0;
         exception_code     <= '0;
         exception_PC       <= '0;
         exception_addr     <= '0;
         csr_mret_active    <= 1'b0;
         pc_redirect        <= 1'b0;
         redirect_PC        <= '0;
         pipeline_stall     <= 1'b0;
         in_trap            <= 1'b0;
      end else if (sync_reset) begin
         activate_exception <= 1'b0;
         is_interrupt       <= 1'b0;
         exception_code     <= '0;
         exception_PC       <= '0;
         exception_addr     <= '0;
         csr_mret_active    <= 1'b0;
         pc_redirect        <= 1'b0;
         redirect_PC        <= '0;
         pipeline_stall     <= 1'b0;
         in_trap            <= 1'b0;
      end else begin
         activate_exception <= (state_d == ST_ENTER);
         csr_mret_active    <= (state_d == ST_MRET);
         pc_redirect        <= (state_d == ST_REDIRECT);
         pipeline_stall     <= (state_d != ST_IDLE);
         if ((state_q == ST_IDLE) && (state_d == ST_ENTER)) begin
            is_interrupt   <= sel_is_int;
            exception_code <= sel_code;
            exception_PC   <= sel_pc;
            exception_addr <= sel_addr;
         end
         if (state_d == ST_REDIRECT) begin
            redirect_PC <= target;
         end
         if ((state_q == ST_ENTER) && is_interrupt) begin
            in_trap <= 1'b1;
         end else if (state_q == ST_MRET) begin
            in_trap <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_reindeer_trap_sequencer.sv
// tb/tb_reindeer_trap_sequencer.sv - directed self-checking bench for reindeer_trap_sequencer
module tb_reindeer_trap_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sync_reset;
   logic [31:0] exe_PC;
   logic [31:0] next_PC;
   logic        exc_req;
   logic [3:0]  exc_code;
   logic [31:0] exc_addr;
   logic        mret_req;
   logic        mem_busy;
   logic        mie, mtie, meie, mtip, meip;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        activate_exception;
   logic        is_interrupt;
   logic [3:0]  exception_code;
   logic [31:0] exception_PC;
   logic [31:0] exception_addr;
   logic        csr_mret_active;
   logic        pc_redirect;
   logic [31:0] redirect_PC;
   logic        pipeline_stall;
   logic        in_trap;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reindeer_trap_sequencer dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .sync_reset         (sync_reset),
      .exe_PC             (exe_PC),
      .next_PC            (next_PC),
      .exc_req            (exc_req),
      .exc_code           (exc_code),
      .exc_addr           (exc_addr),
      .mret_req           (mret_req),
      .mem_busy           (mem_busy),
      .mie                (mie),
      .mtie               (mtie),
      .meie               (meie),
      .mtip               (mtip),
      .meip               (meip),
      .mtvec              (mtvec),
      .mepc               (mepc),
      .activate_exception (activate_exception),
      .is_interrupt       (is_interrupt),
      .exception_code     (exception_code),
      .exception_PC       (exception_PC),
      .exception_addr     (exception_addr),
      .csr_mret_active    (csr_mret_active),
      .pc_redirect        (pc_redirect),
      .redirect_PC        (redirect_PC),
      .pipeline_stall     (pipeline_stall),
      .in_trap            (in_trap)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] exp_timer_target;
`ifdef TRAP_VECTORED_MODE_EN
      exp_timer_target = 32'h0000_031C;
`else
      exp_timer_target = 32'h0000_0300;
`endif
      reset_n = 1'b0; sync_reset = 1'b0;
      exe_PC = '0; next_PC = '0; exc_req = 1'b0; exc_code = '0; exc_addr = '0;
      mret_req = 1'b0; mem_busy = 1'b0;
      mie = 1'b0; mtie = 1'b0; meie = 1'b0; mtip = 1'b0; meip = 1'b0;
      mtvec = 32'h200; mepc = '0;
      step(); step();
      chk("rst_activate", {31'd0, activate_exception}, 32'd0);
      chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
      chk("rst_stall", {31'd0, pipeline_stall}, 32'd0);
      chk("rst_in_trap", {31'd0, in_trap}, 32'd0);
      chk("rst_redirect_pc", redirect_PC, 32'd0);
      reset_n = 1'b1;
      step();

      // Illegal instruction exception
      exc_req = 1'b1; exc_code = 4'd2; exe_PC = 32'h100; exc_addr = 32'hDEADBEEF;
      step();
      exc_req = 1'b0;
      chk("ill_activate", {31'd0, activate_exception}, 32'd1);
      chk("ill_is_int", {31'd0, is_interrupt}, 32'd0);
      chk("ill_code", {28'd0, exception_code}, 32'd2);
      chk("ill_pc", exception_PC, 32'h100);
      chk("ill_addr", exception_addr, 32'hDEADBEEF);
      chk("ill_stall1", {31'd0, pipeline_stall}, 32'd1);
      chk("ill_no_early_redirect", {31'd0, pc_redirect}, 32'd0);
      step();
      chk("ill_redirect", {31'd0, pc_redirect}, 32'd1);
      chk("ill_redirect_pc", redirect_PC, 32'h200);
      chk("ill_activate_off", {31'd0, activate_exception}, 32'd0);
      chk("ill_stall2", {31'd0, pipeline_stall}, 32'd1);
      step();
      chk("ill_redirect_off", {31'd0, pc_redirect}, 32'd0);
      chk("ill_stall_off", {31'd0, pipeline_stall}, 32'd0);

      // Timer interrupt
      mie = 1'b1; mtie = 1'b1; mtip = 1'b1; next_PC = 32'h44; mtvec = 32'h301;
      step();
      mtip = 1'b0;
      chk("tmr_activate", {31'd0, activate_exception}, 32'd1);
      chk("tmr_is_int", {31'd0, is_interrupt}, 32'd1);
      chk("tmr_code", {28'd0, exception_code}, 32'd7);
      chk("tmr_pc", exception_PC, 32'h44);
      chk("tmr_addr", exception_addr, 32'd0);
      step();
      chk("tmr_redirect", {31'd0, pc_redirect}, 32'd1);
      chk("tmr_redirect_pc", redirect_PC, exp_timer_target);
      chk("tmr_in_trap", {31'd0, in_trap}, 32'd1);
      step();
      mret_req = 1'b1; mepc = 32'h44;
      step();
      mret_req = 1'b0;
      chk("mret0_active", {31'd0, csr_mret_active}, 32'd1);
      step();
      chk("mret0_redirect_pc", redirect_PC, 32'h44);
      chk("mret0_in_trap", {31'd0, in_trap}, 32'd0);
      step();

      // Simultaneous exception, external and timer interrupt
      mtvec = 32'h200; meie = 1'b1; meip = 1'b1; mtip = 1'b1;
      exc_req = 1'b1; exc_code = 4'd11; exe_PC = 32'h80; exc_addr = 32'h0; next_PC = 32'h84;
      step();
      exc_req = 1'b0;
      chk("sim_exc_activate", {31'd0, activate_exception}, 32'd1);
      chk("sim_exc_is_int", {31'd0, is_interrupt}, 32'd0);
      chk("sim_exc_pc", exception_PC, 32'h80);
      step();
      chk("sim_exc_redirect_pc", redirect_PC, 32'h200);
      step();
      chk("sim_idle_activate", {31'd0, activate_exception}, 32'd0);
      chk("sim_idle_stall", {31'd0, pipeline_stall}, 32'd0);
      step();
      chk("sim_ext_activate", {31'd0, activate_exception}, 32'd1);
      chk("sim_ext_is_int", {31'd0, is_interrupt}, 32'd1);
      chk("sim_ext_code", {28'd0, exception_code}, 32'd11);
      chk("sim_ext_pc", exception_PC, 32'h84);
      step();
      chk("sim_ext_in_trap", {31'd0, in_trap}, 32'd1);
      step();
      step();
      chk("mask_no_reentry", {31'd0, activate_exception}, 32'd0);
      chk("mask_no_stall", {31'd0, pipeline_stall}, 32'd0);
      chk("mask_in_trap", {31'd0, in_trap}, 32'd1);

      // mret out of the handler, then the still-pending interrupt is retaken
      mret_req = 1'b1; mepc = 32'h44;
      step();
      mret_req = 1'b0;
      chk("mret_active", {31'd0, csr_mret_active}, 32'd1);
      chk("mret_no_activate", {31'd0, activate_exception}, 32'd0);
      step();
      chk("mret_redirect", {31'd0, pc_redirect}, 32'd1);
      chk("mret_redirect_pc", redirect_PC, 32'h44);
      chk("mret_in_trap", {31'd0, in_trap}, 32'd0);
      chk("mret_active_off", {31'd0, csr_mret_active}, 32'd0);
      step();
      step();
      chk("retake_activate", {31'd0, activate_exception}, 32'd1);
      chk("retake_code", {28'd0, exception_code}, 32'd11);
      step(); step();
      meip = 1'b0; mtip = 1'b0; mret_req = 1'b1;
      step();
      mret_req = 1'b0;
      step(); step();
      chk("clean_in_trap", {31'd0, in_trap}, 32'd0);

      // Memory hold-off
      mem_busy = 1'b1; meip = 1'b1;
      step();
      chk("mem_hold1", {31'd0, activate_exception}, 32'd0);
      step();
      chk("mem_hold2", {31'd0, pipeline_stall}, 32'd0);
      mem_busy = 1'b0;
      step();
      chk("mem_entry", {31'd0, activate_exception}, 32'd1);
      chk("mem_entry_code", {28'd0, exception_code}, 32'd11);
      step(); step();
      meip = 1'b0; mret_req = 1'b1;
      step();
      mret_req = 1'b0;
      step(); step();

      // Asynchronous reset during ENTER
      exc_req = 1'b1; exc_code = 4'd2; exe_PC = 32'h100;
      step();
      exc_req = 1'b0;
      chk("arst_pre_activate", {31'd0, activate_exception}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_activate", {31'd0, activate_exception}, 32'd0);
      chk("arst_stall", {31'd0, pipeline_stall}, 32'd0);
      chk("arst_code", {28'd0, exception_code}, 32'd0);
      chk("arst_redirect_pc", redirect_PC, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      chk("arst_no_redirect", {31'd0, pc_redirect}, 32'd0);
      chk("arst_idle", {31'd0, pipeline_stall}, 32'd0);

      // Synchronous reset during ENTER
      exc_req = 1'b1; exc_code = 4'd3; exe_PC = 32'h120;
      step();
      exc_req = 1'b0;
      chk("srst_pre_activate", {31'd0, activate_exception}, 32'd1);
      sync_reset = 1'b1;
      step();
      chk("srst_activate", {31'd0, activate_exception}, 32'd0);
      chk("srst_no_redirect", {31'd0, pc_redirect}, 32'd0);
      chk("srst_stall", {31'd0, pipeline_stall}, 32'd0);
      chk("srst_redirect_pc", redirect_PC, 32'd0);
      chk("srst_pc", exception_PC, 32'd0);
      sync_reset = 1'b0;
      step();
      chk("srst_after_redirect", {31'd0, pc_redirect}, 32'd0);
      chk("srst_after_stall", {31'd0, pipeline_stall}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
